// File: rtl/fft_stage_controller_pkg.sv
// Shared FFT controller definitions: FSM encoding, default sizing and the
// helpers that derive stage count and write-path pipeline depth.
package fft_stage_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FFT_N_DEFAULT      = 32;
  localparam int BF_LATENCY_DEFAULT = 2;

  // Number of radix-2 stages for an N-point transform.
  function automatic int fft_log2(input int n);
    return $clog2(n);
  endfunction

  // Read-to-write distance: one synchronous RAM read plus the butterfly.
  function automatic int fft_pipe(input int bf_latency);
    return 1 + bf_latency;
  endfunction

  localparam int LOG2N  = fft_log2(FFT_N_DEFAULT);
  localparam int PIPE   = fft_pipe(BF_LATENCY_DEFAULT);
  localparam int ADDR_W = LOG2N;

endpackage

// File: rtl/fft_stage_controller_if.sv
// Control/address bundle between the FFT stage controller (master) and the
// butterfly datapath / ping-pong RAM wrapper (slave).
interface fft_stage_controller_if
  import fft_stage_controller_pkg::*;
#(
  parameter int N = FFT_N_DEFAULT
);
  localparam int AW = fft_log2(N);
  localparam int TW = AW - 1;
  localparam int SW = $clog2(AW);

  logic          start;
  logic          busy;
  logic          done;
  logic          bank_select;
  logic [AW-1:0] rd_address1;
  logic [AW-1:0] rd_address2;
  logic [AW-1:0] wr_address1;
  logic [AW-1:0] wr_address2;
  logic          wr_en;
  logic [TW-1:0] twiddle_index;
  logic [SW-1:0] stage;

  modport master (
    input  start,
    output busy, done, bank_select, rd_address1, rd_address2,
           wr_address1, wr_address2, wr_en, twiddle_index, stage
  );

  modport slave (
    output start,
    input  busy, done, bank_select, rd_address1, rd_address2,
           wr_address1, wr_address2, wr_en, twiddle_index, stage
  );
endinterface

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register that turns issued read addresses into write
// addresses once the RAM read and butterfly latency have elapsed.
module fft_addr_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;

  // Shift one slot per clock; cleared on reset so an aborted run leaves no
  // stale write enable in flight.
  // NOTE: this storage is reset on purpose -- it carries the write-enable
  // flag, so garbage here would corrupt RAM after an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fft_stage_controller.sv
// Radix-2 FFT stage sequencer: issues one butterfly per cycle per stage,
// generates ping-pong read/write addresses and twiddle indices, drains the
// butterfly pipeline between stages and swaps banks.
module fft_stage_controller
  import fft_stage_controller_pkg::*;
#(
  parameter int N          = FFT_N_DEFAULT,
  parameter int BF_LATENCY = BF_LATENCY_DEFAULT
) (
  input logic             clk,
  input logic             reset_n,
  fft_stage_controller_if.master bus
);
  localparam int N_LOG2     = fft_log2(N);
  localparam int PIPE_DEPTH = fft_pipe(BF_LATENCY);
  localparam int AW         = N_LOG2;
  localparam int KW         = AW - 1;
  localparam int TW         = AW - 1;
  localparam int SW         = $clog2(AW);
  localparam int FW         = $clog2(PIPE_DEPTH + 1);

  localparam logic [KW-1:0] K_LAST     = KW'(N / 2 - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_DEPTH - 1);

  state_t        state, state_d;
  logic [KW-1:0] k, k_d;
  logic [SW-1:0] stage, stage_d;
  logic [FW-1:0] flush_cnt, flush_d;
  logic          bank, bank_d;

  logic [AW-1:0] k_ext, span, pos, base, tw_full;
  logic [AW-1:0] rd1, rd2;
  logic [TW-1:0] tw;
  logic          issue;
  logic [2*AW:0] dly_out;

  // State and counters register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      stage     <= '0;
      flush_cnt <= '0;
      bank      <= 1'b0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      stage     <= stage_d;
      flush_cnt <= flush_d;
      bank      <= bank_d;
    end
  end

  // Next-state: issue N/2 butterflies, drain PIPE cycles, then next stage.
  // NOTE: every next-value is defaulted to its current value first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state;
    k_d     = k;
    stage_d = stage;
    flush_d = flush_cnt;
    bank_d  = bank;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          k_d     = '0;
          stage_d = '0;
          bank_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (k == K_LAST) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end else begin
          k_d = k + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          k_d = '0;
          if (stage == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage + 1'b1;
            bank_d  = ~bank;
          end
        end else begin
          flush_d = flush_cnt + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly operand addresses and twiddle index; shifts replace the span
  // multiplies. Held at zero whenever no butterfly is being issued.
  always_comb begin
    k_ext   = {1'b0, k};
    span    = AW'(1) << stage;
    pos     = k_ext & (span - AW'(1));
    base    = ((k_ext >> stage) << stage) << 1;
    tw_full = pos << (LAST_STAGE - stage);
    issue   = (state == ST_RUN);
    rd1     = '0;
    rd2     = '0;
    tw      = '0;
    if (issue) begin
      rd1 = base | pos;
      rd2 = base | pos | span;
      tw  = tw_full[TW-1:0];
    end
  end

  fft_addr_delay #(
    .WIDTH (2 * AW + 1),
    .DEPTH (PIPE_DEPTH)
  ) u_addr_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     ({issue, rd1, rd2}),
    .dout    (dly_out)
  );

  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE);
  assign bus.bank_select   = bank;
  assign bus.stage         = stage;
  assign bus.rd_address1   = rd1;
  assign bus.rd_address2   = rd2;
  assign bus.twiddle_index = tw;
  assign bus.wr_en         = dly_out[2*AW];
  assign bus.wr_address1   = dly_out[2*AW-1:AW];
  assign bus.wr_address2   = dly_out[AW-1:0];
endmodule

// File: tb/tb_fft_stage_controller.sv
// Scoreboard bench for fft_stage_controller: a transform-level model queues
// the expected reads, writes and done pulse for every accepted start; a
// negedge monitor pops and compares as the DUT presents them.
module tb_fft_stage_controller;
  localparam int N          = 32;
  localparam int BF_LATENCY = 2;
  localparam int PIPE       = 1 + BF_LATENCY;
  localparam int LOGN       = $clog2(N);
  localparam int HALF       = N / 2;
  localparam int STAGE_LEN  = HALF + PIPE;
  localparam int LAT        = LOGN * STAGE_LEN;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fft_stage_controller_if #(.N(N)) bus ();

  fft_stage_controller #(
    .N          (N),
    .BF_LATENCY (BF_LATENCY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int cyc;
    int a1;
    int a2;
    int tw;
    int st;
  } op_t;

  op_t rd_q[$];
  op_t wr_q[$];
  int  done_q[$];

  int cyc         = 0;
  int model_ready = 0;
  int busy_from   = -1;
  int busy_until  = -1;
  int wr_seen     = 0;
  int n_checks    = 0;
  int n_fail      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transform model: every butterfly of every stage, with its issue cycle.
  function automatic void accept(input int s);
    for (int st = 0; st < LOGN; st++) begin
      for (int k = 0; k < HALF; k++) begin
        int span, pos, grp, a1, a2, tw, t;
        span = 1 << st;
        pos  = k % span;
        grp  = k / span;
        a1   = grp * 2 * span + pos;
        a2   = a1 + span;
        tw   = pos * (HALF / span);
        t    = s + st * STAGE_LEN + k;
        rd_q.push_back('{t, a1, a2, tw, st});
        wr_q.push_back('{t + PIPE, a1, a2, tw, st});
      end
    end
    done_q.push_back(s + LAT);
    busy_from   = s;
    busy_until  = s + LAT;
    model_ready = s + LAT + 2;
    wr_seen     = 0;
  endfunction

  // Cycle counter and start acceptance rule of the model.
  always @(posedge clk) begin
    int c;
    c = cyc + 1;
    cyc <= c;
    if (reset_n && bus.start && c >= model_ready) accept(c);
  end

  // Monitor: compare whatever the DUT presents against the queued model.
  always @(negedge clk) begin
    op_t op;
    int  exp_busy;
    if (reset_n) begin
      exp_busy = (cyc >= busy_from && cyc <= busy_until) ? 1 : 0;
      check("busy", int'(bus.busy), exp_busy);
      if (exp_busy == 0) check("bank_idle", int'(bus.bank_select), 0);

      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        op = rd_q.pop_front();
        check("rd_address1", int'(bus.rd_address1), op.a1);
        check("rd_address2", int'(bus.rd_address2), op.a2);
        check("twiddle_index", int'(bus.twiddle_index), op.tw);
        check("stage", int'(bus.stage), op.st);
        check("bank_on_read", int'(bus.bank_select), op.st % 2);
      end else begin
        check("rd_address1_hold", int'(bus.rd_address1), 0);
        check("rd_address2_hold", int'(bus.rd_address2), 0);
      end

      if (bus.wr_en) begin
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
          op = wr_q.pop_front();
          wr_seen++;
          check("wr_address1", int'(bus.wr_address1), op.a1);
          check("wr_address2", int'(bus.wr_address2), op.a2);
          check("bank_on_write", int'(bus.bank_select), op.st % 2);
        end else begin
          check("wr_en_unexpected", int'(bus.wr_en), 0);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        op = wr_q.pop_front();
        check("wr_en_missing", int'(bus.wr_en), 1);
      end

      if (bus.done) begin
        if (done_q.size() > 0 && done_q[0] == cyc) begin
          void'(done_q.pop_front());
          check("wr_count", wr_seen, HALF * LOGN);
          check("bank_final", int'(bus.bank_select), (LOGN - 1) % 2);
        end else begin
          check("done_unexpected", int'(bus.done), 0);
        end
      end else if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        check("done_missing", int'(bus.done), 1);
      end
    end
  end

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_bank", int'(bus.bank_select), 0);
    check("rst_rd1", int'(bus.rd_address1), 0);
    check("rst_rd2", int'(bus.rd_address2), 0);
    check("rst_wr1", int'(bus.wr_address1), 0);
    check("rst_wr2", int'(bus.wr_address2), 0);
    check("rst_twiddle", int'(bus.twiddle_index), 0);
    check("rst_stage", int'(bus.stage), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_from  = -1;
    busy_until = -1;
    wr_seen    = 0;
    repeat (cycles) @(negedge clk);
    reset_n     = 1'b1;
    model_ready = cyc + 1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((cyc <= busy_until + 1 || done_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: waited %0d cycles, limit %0d", n, budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic stray_starts(input int count);
    repeat (count) begin
      repeat ($urandom_range(3, 20)) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    #2;
    apply_reset(3);

    // Start on the first edge after reset release, then ignored pulses.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    stray_starts(3);
    wait_idle(400);

    // Start held high across two full transforms and into a third.
    @(negedge clk);
    bus.start = 1'b1;
    repeat (2 * (LAT + 2) + 5) @(negedge clk);
    bus.start = 1'b0;
    wait_idle(400);

    // Randomly spaced transforms with stray starts while busy.
    repeat (3) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      pulse_start();
      stray_starts($urandom_range(1, 3));
      wait_idle(400);
    end

    // Abort 40 cycles into a transform; nothing may be written afterwards.
    pulse_start();
    repeat (39) @(posedge clk);
    #2;
    apply_reset(2);
    repeat (150) @(negedge clk);

    // Recovery transform after the abort.
    pulse_start();
    wait_idle(400);

    check("queues_drained", rd_q.size() + wr_q.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end
endmodule
